// File: rtl/brent_kung_pipe_alu.sv
// Streaming Brent-Kung adder/subtractor with valid/ready handshakes and an accumulator.
// Pipeline: S1 operand register -> optional up-sweep register -> output register.
module brent_kung_pipe_alu #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MID_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);
    localparam int unsigned LOG = $clog2(WIDTH);

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ACC  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    logic             adv, accept, acc_busy, mid_busy;
    logic [WIDTH-1:0] acc_q;

    logic             s1_valid_q;
    op_e              s1_mode_q;
    logic [WIDTH-1:0] s1_x_q, s1_y_q;
    logic             s1_c0_q;
    logic [WIDTH-1:0] x_d, y_d;
    logic             c0_d;

    assign adv      = !out_valid || out_ready;
    assign acc_busy = (s1_valid_q && s1_mode_q[1]) || mid_busy;
    assign in_ready = adv && !(in_mode[1] && acc_busy);
    assign accept   = in_valid && in_ready;

    always_comb begin
        x_d  = in_a;
        y_d  = in_b;
        c0_d = in_cin;
        case (op_e'(in_mode))
            OP_ADD: ;
            OP_SUB: begin
                y_d  = ~in_b;
                c0_d = 1'b1;
            end
            OP_ACC: begin
                x_d = acc_q;
                y_d = in_a;
            end
            default: begin
                x_d  = '0;
                y_d  = in_a;
                c0_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= OP_ADD;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_c0_q    <= 1'b0;
        end else if (adv) begin
            s1_valid_q <= accept;
            s1_mode_q  <= op_e'(in_mode);
            s1_x_q     <= x_d;
            s1_y_q     <= y_d;
            s1_c0_q    <= c0_d;
        end
    end

    // Up-sweep; carry-in is folded into bit 0's generate so group G values are true carries.
    logic [WIDTH-1:0] p0, gu, pu;
    always_comb begin
        p0    = s1_x_q ^ s1_y_q;
        gu    = s1_x_q & s1_y_q;
        gu[0] = gu[0] | (p0[0] & s1_c0_q);
        pu    = p0;
        for (int unsigned l = 1; l <= LOG; l++) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (((i + 1) % (1 << l)) == 0) begin
                    gu[i] = gu[i] | (pu[i] & gu[i - (1 << (l - 1))]);
                    pu[i] = pu[i] & pu[i - (1 << (l - 1))];
                end
            end
        end
    end

    logic             sm_valid;
    op_e              sm_mode;
    logic [WIDTH-1:0] sm_g, sm_pg, sm_p;
    logic             sm_c0, sm_xm, sm_ym;

    generate
        if (MID_REG != 0) begin : g_mid
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sm_valid <= 1'b0;
                    sm_mode  <= OP_ADD;
                    sm_g     <= '0;
                    sm_pg    <= '0;
                    sm_p     <= '0;
                    sm_c0    <= 1'b0;
                    sm_xm    <= 1'b0;
                    sm_ym    <= 1'b0;
                end else if (adv) begin
                    sm_valid <= s1_valid_q;
                    sm_mode  <= s1_mode_q;
                    sm_g     <= gu;
                    sm_pg    <= pu;
                    sm_p     <= p0;
                    sm_c0    <= s1_c0_q;
                    sm_xm    <= s1_x_q[WIDTH-1];
                    sm_ym    <= s1_y_q[WIDTH-1];
                end
            end
            assign mid_busy = sm_valid && sm_mode[1];
        end else begin : g_nomid
            always_comb begin
                sm_valid = s1_valid_q;
                sm_mode  = s1_mode_q;
                sm_g     = gu;
                sm_pg    = pu;
                sm_p     = p0;
                sm_c0    = s1_c0_q;
                sm_xm    = s1_x_q[WIDTH-1];
                sm_ym    = s1_y_q[WIDTH-1];
            end
            assign mid_busy = 1'b0;
        end
    endgenerate

    // Down-sweep fills the odd positions left by the up-sweep, coarsest span first.
    logic [WIDTH-1:0] gd, carry, sum_d;
    logic             cout_d, ovf_d;
    always_comb begin
        gd = sm_g;
        for (int unsigned l = LOG - 1; l >= 1; l--) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if ((i >= (1 << l)) && (((i + 1) % (1 << l)) == (1 << (l - 1)))) begin
                    gd[i] = gd[i] | (sm_pg[i] & gd[i - (1 << (l - 1))]);
                end
            end
        end
        carry  = {gd[WIDTH-2:0], sm_c0};
        sum_d  = sm_p ^ carry;
        cout_d = gd[WIDTH-1];
        ovf_d  = (sm_xm == sm_ym) && (sum_d[WIDTH-1] != sm_xm);
        if (sm_mode == OP_LOAD) begin
            cout_d = 1'b0;
            ovf_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b1;
            acc_q     <= '0;
        end else if (adv) begin
            out_valid <= sm_valid;
            out_sum   <= sum_d;
            out_cout  <= cout_d;
            out_ovf   <= ovf_d;
            out_zero  <= (sum_d == '0);
            if (sm_valid && sm_mode[1]) begin
                acc_q <= sum_d;
            end
        end
    end

endmodule

// File: tb/tb_brent_kung_pipe_alu.sv
// Randomised and directed bench for brent_kung_pipe_alu against an arithmetic reference model.
`timescale 1ns/1ps
module tb_brent_kung_pipe_alu;
    localparam int W = 8;
    localparam int L = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, out_ovf, out_zero;
    logic [1:0]   in_mode;
    logic [W-1:0] in_a, in_b, out_sum;

    logic         t_valid, t_ready, t_cin, t_ovalid, t_ordy, t_cout, t_ovf, t_zero;
    logic [1:0]   t_mode;
    logic [W-1:0] t_a, t_b, t_sum;

    brent_kung_pipe_alu #(.WIDTH(W), .MID_REG(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
    );

    brent_kung_pipe_alu #(.WIDTH(W), .MID_REG(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(t_valid), .in_ready(t_ready), .in_mode(t_mode),
        .in_a(t_a), .in_b(t_b), .in_cin(t_cin), .out_valid(t_ovalid), .out_ready(t_ordy),
        .out_sum(t_sum), .out_cout(t_cout), .out_ovf(t_ovf), .out_zero(t_zero)
    );

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    typedef struct packed {
        logic       v;
        logic [1:0] mode;
        res_t       r;
    } slot_t;

    slot_t        pipe [L];
    logic [W-1:0] acc_m;
    int           checks = 0;
    int           passed = 0;
    logic         chk_en = 1'b0;
    int           cyc = 0;
    res_t         got_q[$];
    int           out_cyc_q[$];
    int           acc_cyc_q[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else passed++;
    endfunction

    // Reference arithmetic: plain integer sums; carry and overflow from range tests.
    function automatic res_t ref_calc(input logic [1:0] mode, input logic [W-1:0] a,
                                      input logic [W-1:0] b, input logic cin, input logic [W-1:0] acc);
        int ua, ub, uacc, sa, sb, sacc, u, s;
        res_t r;
        ua   = int'(a);
        ub   = int'(b);
        uacc = int'(acc);
        sa   = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
        sb   = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
        sacc = (uacc >= (1 << (W - 1))) ? uacc - (1 << W) : uacc;
        case (mode)
            2'b00:   begin u = ua + ub + int'(cin);   s = sa + sb + int'(cin);   end
            2'b01:   begin u = ua - ub;               s = sa - sb;               end
            2'b10:   begin u = uacc + ua + int'(cin); s = sacc + sa + int'(cin); end
            default: begin u = ua;                    s = sa;                    end
        endcase
        r.sum  = u[W-1:0];
        r.cout = (mode == 2'b01) ? (ua >= ub) : (mode == 2'b11) ? 1'b0 : (u >= (1 << W));
        r.ovf  = (mode == 2'b11) ? 1'b0 : ((s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1))));
        r.zero = (r.sum == '0);
        return r;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < L; k++) pipe[k] = '0;
        acc_m = '0;
    endfunction

    // Output compare against the model's final pipeline slot.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("out_valid", {31'b0, out_valid}, {31'b0, pipe[L-1].v});
            if (pipe[L-1].v) begin
                check("out_sum", {24'b0, out_sum}, {24'b0, pipe[L-1].r.sum});
                check("out_cout", {31'b0, out_cout}, {31'b0, pipe[L-1].r.cout});
                check("out_ovf", {31'b0, out_ovf}, {31'b0, pipe[L-1].r.ovf});
                check("out_zero", {31'b0, out_zero}, {31'b0, pipe[L-1].r.zero});
            end
        end
    end

    // One clock of stimulus; entered and left at negedge+2.
    task automatic cycle(input logic iv, input logic [1:0] m, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic c, input logic ordy, output logic ok);
        logic  adv, busy, exp_rdy;
        slot_t nw;
        in_valid = iv; in_mode = m; in_a = a; in_b = b; in_cin = c; out_ready = ordy;
        #1;
        cyc++;
        if (out_valid && ordy) begin
            got_q.push_back({out_sum, out_cout, out_ovf, out_zero});
            out_cyc_q.push_back(cyc);
        end
        adv  = !pipe[L-1].v || ordy;
        busy = 1'b0;
        for (int k = 0; k < L - 1; k++) if (pipe[k].v && pipe[k].mode[1]) busy = 1'b1;
        exp_rdy = adv && !(m[1] && busy);
        check("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        ok = iv && exp_rdy;
        if (adv) begin
            nw = '0;
            if (ok) begin
                nw = {1'b1, m, ref_calc(m, a, b, c, acc_m)};
                acc_cyc_q.push_back(cyc);
            end
            for (int k = L - 1; k > 0; k--) pipe[k] = pipe[k-1];
            pipe[0] = nw;
            if (pipe[L-1].v && pipe[L-1].mode[1]) acc_m = pipe[L-1].r.sum;
        end
        @(negedge clk);
        #2;
    endtask

    task automatic send(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic ok;
        int   tries;
        ok = 1'b0;
        tries = 0;
        while (!ok && tries < 20) begin
            cycle(1'b1, m, a, b, c, 1'b1, ok);
            tries++;
        end
        if (!ok) begin
            checks++;
            $display("FAIL send_timeout: beat mode %0d not accepted within 20 cycles", m);
        end
    endtask

    task automatic idle(input int n);
        logic ok;
        for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, '0, '0, 1'b0, 1'b1, ok);
    endtask

    task automatic check_res(input string name, input int idx, input res_t exp);
        if (idx >= got_q.size()) begin
            checks++;
            $display("FAIL %s: result %0d missing, got %0d results", name, idx, got_q.size());
        end else begin
            check(name, {21'b0, got_q[idx]}, {21'b0, exp});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         ok, pend, pc;
        logic [1:0]   pm;
        logic [W-1:0] pa, pb;
        logic [W-1:0] bp_a [6];
        logic [W-1:0] bp_b [6];
        int           sent, exp0[$], first_acc, first_out, last_out, nout, gaps;

        rst = 1'b1;
        in_valid = 1'b0; in_mode = '0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
        t_valid = 1'b0; t_mode = '0; t_a = '0; t_b = '0; t_cin = 1'b0; t_ordy = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        #2;
        check("rst out_valid", {31'b0, out_valid}, 32'd0);
        check("rst out_sum", {24'b0, out_sum}, 32'd0);
        check("rst out_zero", {31'b0, out_zero}, 32'd1);
        check("rst out_cout/ovf", {30'b0, out_cout, out_ovf}, 32'd0);
        check("rst acc", {24'b0, dut.acc_q}, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Directed arithmetic corners.
        got_q.delete();
        send(2'b00, 8'd200, 8'd100, 1'b1);
        send(2'b00, 8'd100, 8'd50, 1'b0);
        send(2'b00, 8'd0, 8'd0, 1'b0);
        send(2'b01, 8'd5, 8'd7, 1'b0);
        send(2'b01, 8'd128, 8'd1, 1'b0);
        idle(L + 1);
        check_res("add 200+100+1", 0, {8'd45, 1'b1, 1'b0, 1'b0});
        check_res("add 100+50", 1, {8'd150, 1'b0, 1'b1, 1'b0});
        check_res("add 0+0", 2, {8'd0, 1'b0, 1'b0, 1'b1});
        check_res("sub 5-7", 3, {8'd254, 1'b0, 1'b0, 1'b0});
        check_res("sub 128-1", 4, {8'd127, 1'b1, 1'b1, 1'b0});

        // Accumulator chain with in_valid held until each op is taken.
        got_q.delete();
        send(2'b11, 8'd10, 8'd99, 1'b1);
        send(2'b10, 8'd20, 8'd99, 1'b0);
        send(2'b10, 8'd250, 8'd99, 1'b0);
        idle(L + 1);
        check_res("load 10", 0, {8'd10, 1'b0, 1'b0, 1'b0});
        check_res("acc +20", 1, {8'd30, 1'b0, 1'b0, 1'b0});
        check_res("acc +250", 2, {8'd24, 1'b1, 1'b0, 1'b0});
        check("acc after chain", {24'b0, dut.acc_q}, 32'd24);

        // Backpressure: consumer stalls four cycles while six ADDs stream in.
        got_q.delete();
        for (int i = 0; i < 6; i++) begin
            bp_a[i] = W'($urandom);
            bp_b[i] = W'($urandom);
        end
        sent = 0;
        for (int c = 0; c < 30 && got_q.size() < 6; c++) begin
            cycle(sent < 6, 2'b00, bp_a[sent % 6], bp_b[sent % 6], 1'b0, !(c >= 2 && c < 6), ok);
            if (ok) sent++;
        end
        check("bp result count", got_q.size(), 32'd6);
        for (int i = 0; i < 6 && i < got_q.size(); i++)
            check("bp order", {24'b0, got_q[i].sum}, 32'((int'(bp_a[i]) + int'(bp_b[i])) % 256));

        // Throughput: 16 ADDs, consumer always ready.
        got_q.delete(); out_cyc_q.delete(); acc_cyc_q.delete();
        for (int i = 0; i < 16; i++) cycle(1'b1, 2'b00, W'($urandom), W'($urandom), 1'($urandom), 1'b1, ok);
        idle(L + 1);
        check("tp accepts", acc_cyc_q.size(), 32'd16);
        check("tp results", out_cyc_q.size(), 32'd16);
        if (acc_cyc_q.size() == 16 && out_cyc_q.size() == 16) begin
            check("tp latency", out_cyc_q[0] - acc_cyc_q[0], L);
            check("tp out span", out_cyc_q[15] - out_cyc_q[0], 32'd15);
            check("tp acc span", acc_cyc_q[15] - acc_cyc_q[0], 32'd15);
        end

        // Reset asserted mid-stream with a nonzero accumulator.
        send(2'b11, 8'd77, 8'd0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'b00, 8'd11, 8'd22, 1'b0, 1'b1, ok);
        check("acc before rst", {24'b0, dut.acc_q}, 32'd77);
        rst = 1'b1;
        #1;
        check("mid rst out_valid", {31'b0, out_valid}, 32'd0);
        check("mid rst out_sum", {24'b0, out_sum}, 32'd0);
        check("mid rst out_zero", {31'b0, out_zero}, 32'd1);
        check("mid rst acc", {24'b0, dut.acc_q}, 32'd0);
        chk_en = 1'b0;
        in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        chk_en = 1'b1;
        got_q.delete(); out_cyc_q.delete(); acc_cyc_q.delete();
        cycle(1'b1, 2'b00, 8'd3, 8'd4, 1'b0, 1'b1, ok);
        check("post rst accept", {31'b0, ok}, 32'd1);
        idle(L + 1);
        check("post rst count", got_q.size(), 32'd1);
        check_res("post rst 3+4", 0, {8'd7, 1'b0, 1'b0, 1'b0});
        if (out_cyc_q.size() > 0 && acc_cyc_q.size() > 0)
            check("post rst latency", out_cyc_q[0] - acc_cyc_q[0], L);

        // Random traffic; a refused beat is held unchanged until taken.
        pend = 1'b0; pm = '0; pa = '0; pb = '0; pc = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!pend) begin
                pend = ($urandom_range(0, 3) != 0);
                pm   = 2'($urandom);
                pa   = ($urandom_range(0, 7) == 0) ? {W{1'b1}} : W'($urandom);
                pb   = ($urandom_range(0, 7) == 0) ? {1'b1, {(W-1){1'b0}}} : W'($urandom);
                pc   = 1'($urandom);
            end
            cycle(pend, pm, pa, pb, pc, $urandom_range(0, 3) != 0, ok);
            if (ok) pend = 1'b0;
        end
        idle(L + 2);
        chk_en = 1'b0;

        // MID_REG=0 instance: two-cycle latency, one ADD per cycle.
        sent = 0; first_acc = -1; first_out = -1; last_out = -1; nout = 0; gaps = 0;
        for (int c = 0; c < 40 && nout < 16; c++) begin
            t_valid = (sent < 16); t_mode = 2'b00; t_a = W'($urandom); t_b = W'($urandom);
            t_cin = 1'($urandom); t_ordy = 1'b1;
            #1;
            if (t_ovalid) begin
                if (exp0.size() == 0) begin
                    checks++;
                    $display("FAIL dut0 spurious: result %0h with none outstanding", t_sum);
                end else begin
                    check("dut0 sum", {23'b0, t_cout, t_sum}, 32'(exp0.pop_front()));
                end
                if (first_out < 0) first_out = c;
                if (last_out >= 0 && c != last_out + 1) gaps++;
                last_out = c;
                nout++;
            end
            if (t_valid) begin
                check("dut0 in_ready", {31'b0, t_ready}, 32'd1);
                if (t_ready) begin
                    exp0.push_back(int'(t_a) + int'(t_b) + int'(t_cin));
                    if (first_acc < 0) first_acc = c;
                    sent++;
                end
            end
            @(negedge clk);
            #2;
        end
        t_valid = 1'b0;
        check("dut0 results", nout, 32'd16);
        check("dut0 latency", first_out - first_acc, 32'd2);
        check("dut0 gaps", gaps, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
